// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and constants for the multi-channel clock-enable
// generator.
//   DIV_W / NCH / SEL_W : default counter width, channel count and select width
//   div_t               : divide-value type at the default width
//   DIV_SCAN_1KHZ       : divide value giving a 1 kHz tick at the board clock
//   DIV_BLINK_2HZ       : divide value giving a 2 Hz tick at the board clock
package clkdiv_pkg;

  localparam int DIV_W = 21;
  localparam int NCH   = 4;
  localparam int SEL_W = 4;

  typedef logic [DIV_W-1:0] div_t;

  // Board oscillator frequency. A 2 Hz tick must fit in DIV_W bits, which
  // bounds the usable board clock to about 4.19 MHz.
  localparam int unsigned BOARD_CLK_HZ = 4_000_000;

  // Divide value N for a tick rate of hz: the period is N+1 cycles.
  function automatic div_t div_for_hz(input int unsigned hz);
    return div_t'(BOARD_CLK_HZ / hz - 1);
  endfunction

  localparam div_t DIV_SCAN_1KHZ = div_for_hz(1000);
  localparam div_t DIV_BLINK_2HZ = div_for_hz(2);

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with a counter, an active divide value
// and a pending divide value. The pending value is loaded into the active
// register at each terminal count or on sync, so a running period always
// completes with the old value.
// Optional feature macro: CLKDIV_SQUARE_EN builds the square-wave flop.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (counter holds when low)
//   sync     : synchronous restart (dominates en and terminal count)
//   we, data : write strobe and new divide value for this channel
//   tick     : registered one-cycle strobe at terminal count
//   sq       : registered 50 % square wave, or constant 0 when not built
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W       = clkdiv_pkg::DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [DIV_W-1:0] data,
  output logic             tick,
  output logic             sq
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] act_reg;
  logic [DIV_W-1:0] pend_reg;
  logic [DIV_W-1:0] reload_next;
  logic             tick_reg;
  logic             tc;

  // A write landing on the reload cycle bypasses the pending register.
  assign reload_next = we ? data : pend_reg;
  assign tc          = (cnt_reg == act_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      act_reg  <= DEFAULT_DIV;
      pend_reg <= DEFAULT_DIV;
      tick_reg <= 1'b0;
    end else begin
      if (we) begin
        pend_reg <= data;
      end
      if (sync) begin
        cnt_reg  <= '0;
        act_reg  <= reload_next;
        tick_reg <= 1'b0;
      end else if (en) begin
        if (tc) begin
          cnt_reg  <= '0;
          act_reg  <= reload_next;
          tick_reg <= 1'b1;
        end else begin
          cnt_reg  <= cnt_reg + 1'b1;
          tick_reg <= 1'b0;
        end
      end else begin
        tick_reg <= 1'b0;
      end
    end
  end

  assign tick = tick_reg;

`ifdef CLKDIV_SQUARE_EN
  logic sq_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_reg <= 1'b0;
    end else if (sync) begin
      sq_reg <= 1'b0;
    end else if (en && tc) begin
      sq_reg <= ~sq_reg;
    end
  end

  assign sq = sq_reg;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: parametrised multi-channel clock-enable generator. Each
// channel has its own runtime-programmable divide value N (period N+1) and
// produces a one-cycle tick and, optionally, a square wave of period 2(N+1).
// Optional feature macro: CLKDIV_SQUARE_EN (square-wave outputs; when
// undefined sq is tied to zero).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : global count enable
//   sync     : synchronous restart of all channels
//   div_we   : write strobe for a divide value
//   div_sel  : channel index for the write (values >= NCH are ignored)
//   div_data : new divide value N
//   tick     : per-channel registered one-cycle strobe
//   sq       : per-channel registered square wave
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W       = clkdiv_pkg::DIV_W,
  parameter int               NCH         = clkdiv_pkg::NCH,
  parameter int               SEL_W       = clkdiv_pkg::SEL_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_data,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  logic [NCH-1:0] we_ch;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      // Only indices 0..NCH-1 match, so out-of-range selects write nothing.
      localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(gi);

      assign we_ch[gi] = div_we && (div_sel == CH_IDX);

      clkdiv_channel #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sync (sync),
        .we   (we_ch[gi]),
        .data (div_data),
        .tick (tick[gi]),
        .sq   (sq[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi (DIV_W=4, NCH=4). Stimulus pushes the expected
// tick/sq vectors for every cycle into a queue; a monitor pops and compares
// one entry just after each rising edge. The reference model counts down the
// enabled edges left in each channel's current period.
module tb_clkdiv_multi;

  localparam int DIV_W = 4;
  localparam int NCH   = 4;
  localparam int SEL_W = 4;
  localparam int DEF   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sync;
  logic             div_we;
  logic [SEL_W-1:0] div_sel;
  logic [DIV_W-1:0] div_data;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  clkdiv_multi #(
    .DIV_W       (DIV_W),
    .NCH         (NCH),
    .SEL_W       (SEL_W),
    .DEFAULT_DIV (4'd15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_we   (div_we),
    .div_sel  (div_sel),
    .div_data (div_data),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // Reference model: enabled edges left until the next tick, pending N,
  // square-wave phase.
  int left_m [NCH];
  int pend_m [NCH];
  bit sq_m   [NCH];

  task automatic model_step(input bit r, input bit e, input bit s, input bit w,
                            input int sel, input int d,
                            output logic [NCH-1:0] t_o,
                            output logic [NCH-1:0] s_o);
    t_o = '0;
    s_o = '0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        pend_m[c] = DEF;
        left_m[c] = DEF + 1;
        sq_m[c]   = 1'b0;
      end
    end else begin
      // Updating pending first makes a same-cycle write visible to a reload.
      if (w && sel < NCH) pend_m[sel] = d;
      for (int c = 0; c < NCH; c++) begin
        if (s) begin
          left_m[c] = pend_m[c] + 1;
          sq_m[c]   = 1'b0;
        end else if (e) begin
          left_m[c] = left_m[c] - 1;
          if (left_m[c] == 0) begin
            t_o[c]    = 1'b1;
            sq_m[c]   = ~sq_m[c];
            left_m[c] = pend_m[c] + 1;
          end
        end
      end
    end
`ifdef CLKDIV_SQUARE_EN
    for (int c = 0; c < NCH; c++) s_o[c] = sq_m[c];
`endif
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit w,
                      input int sel, input int d);
    exp_t x;
    rst      = r;
    en       = e;
    sync     = s;
    div_we   = w;
    div_sel  = SEL_W'(sel);
    div_data = DIV_W'(d);
    model_step(r, e, s, w, sel, d, x.tick, x.sq);
    x.id = txn_id;
    txn_id++;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr(input int sel, input int d);
    step(1'b0, 1'b1, 1'b0, 1'b1, sel, d);
  endtask

  // Monitor: compare just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        checks += 2;
        if (tick !== x.tick) begin
          errors++;
          $display("FAIL tick txn %0d: got %b expected %b", x.id, tick, x.tick);
        end
        if (sq !== x.sq) begin
          errors++;
          $display("FAIL sq txn %0d: got %b expected %b", x.id, sq, x.sq);
        end
        $display("txn %0d rst=%b en=%b sync=%b tick=%b sq=%b", x.id, rst, en,
                 sync, tick, sq);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; div_we = 1'b0;
    div_sel = '0; div_data = '0;
    @(negedge clk);

    // Reset defaults: first tick 16 enabled edges after release.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run(20, 1'b1);
    // Reset mid-count, then the full 16-cycle period again.
    run(5, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    run(36, 1'b1);

    // N=3 on channel 1 after sync.
    wr(1, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(20, 1'b1);

    // N=0 on channel 0; drop en for 5 cycles.
    wr(0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(6, 1'b1);
    run(5, 1'b0);
    run(6, 1'b1);

    // N=9 on channel 2, change to N=2 mid-period.
    wr(2, 9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(3, 1'b1);
    wr(2, 2);
    run(20, 1'b1);

    // Channel 3 at N=1: two back-to-back writes, one lands on terminal count.
    wr(3, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(3, 1'b1);
    wr(3, 4);
    wr(3, 4);
    run(12, 1'b1);

    // Out-of-range selects are ignored.
    wr(4, 0);
    wr(15, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(20, 1'b1);

    // All channels N=3, sync with en low, then aligned ticks.
    for (int c = 0; c < NCH; c++) wr(c, 3);
    run(2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run(2, 1'b0);
    run(14, 1'b1);

    // Randomised phase.
    for (int i = 0; i < 2000; i++) begin
      bit r, e, s, w;
      int sel, d;
      r   = ($urandom_range(0, 299) == 0);
      e   = ($urandom_range(0, 99) < 85);
      s   = ($urandom_range(0, 99) < 3);
      w   = ($urandom_range(0, 99) < 15);
      sel = $urandom_range(0, 5);
      d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                        : $urandom_range(0, 5);
      step(r, e, s, w, sel, d);
    end

    run(2, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock-enable generator: the successor to the team's fixed 21-bit free-running divider for the display clock. Every channel has its own runtime-programmable divide ratio. Each channel produces a one-cycle `tick` strobe and an optional 50 %-duty square wave. It sits between the board clock and the display scanner, debouncer and blink logic. Consumers gate logic with `tick` instead of using divided clocks.

## Interface
- `DIV_W`, 21: width of each channel's counter and divide register.
- `NCH`, 4: number of independent channels (1..16).
- `SEL_W`, 4: width of `div_sel`; must be ≥ ceil(log2(NCH)).
- `DEFAULT_DIV`, 2**DIV_W−1: reset value of every channel's divide register. The reset period is 2**DIV_W cycles.

Ports:
- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `rst`, in, 1: reset; asynchronous, active-high.
- `en`, in, 1: global count enable. When low, all counters hold.
- `sync`, in, 1: synchronous restart of all channels.
- `div_we`, in, 1: write strobe for a divide value.
- `div_sel`, in, SEL_W: channel index for the write.
- `div_data`, in, DIV_W: new divide value N; the period is N+1 cycles.
- `tick`, out, NCH: per-channel one-cycle strobe, registered.
- `sq`, out, NCH: per-channel square wave, registered; its period is 2·(N+1) cycles.

## Operation
- Per channel state:
  - `cnt[DIV_W]`
  - `act[DIV_W]`: active divide value.
  - `pend[DIV_W]`: pending divide value.
  - `tick` and `sq` flops.
- Reset values:
  - `cnt` = 0.
  - `act` = `pend` = DEFAULT_DIV.
  - `tick` = 0 and `sq` = 0 on all channels.
- Write: when `div_we` is high and `div_sel` < NCH, `pend[div_sel]` ← `div_data`.
  - `act` is not updated immediately; the write has no effect on the running period.
  - A write with `div_sel` ≥ NCH is ignored.
- Counting, per channel, when `en` is high and `sync` is low:
  - If `cnt` == `act`: `cnt` ← 0, `act` ← `pend`, `tick` ← 1, `sq` ← ~`sq`.
  - Otherwise: `cnt` ← `cnt`+1 and `tick` ← 0.
  - `cnt` never exceeds `act`, so no wrap-around occurs. Arithmetic is unsigned, DIV_W bits.
- When `en` is low: `cnt`, `act` and `sq` hold, and `tick` ← 0. Writes are still accepted.
- When `sync` is high, regardless of `en`, on all channels: `cnt` ← 0, `act` ← `pend`, `tick` ← 0, `sq` ← 0.
- Simultaneous events:
  - `sync` dominates terminal count and `en`.
  - A write in the same cycle as that channel's terminal count or `sync` is bypassed: `act` loads `div_data` directly.
- N = 0: `tick` is high every enabled cycle, and `sq` toggles every enabled cycle (clk/2).
- Reset mid-operation returns every channel to its reset values immediately. Programmed divide values are lost.

## Timing
- `tick` and `sq` are flop outputs with no combinational path from any input.
- After reset deassertion with `en` held high, the first `tick` is high in the cycle following the edge where `cnt` == `act`. It is seen N+1 edges after the first enabled edge.
- In steady state, `tick` recurs every N+1 enabled cycles and lasts exactly one cycle.
- A new value written in cycle t takes effect from the first terminal count at or after t. The period in progress always completes with the old value, unless `sync` intervenes.
- `sync` asserted at edge t: all `cnt` = 0 after t, and the next tick is N+1 enabled edges later. Channels stay phase-aligned when their N values are equal.

## Configuration
- `CLKDIV_SQUARE_EN`:
  - Defined: the `sq` flops and toggle logic are built as described above.
  - Undefined: `sq` is tied to all-zeros, no `sq` flops exist, and `tick` behaviour is unchanged.

## Structure
- Package `clkdiv_pkg`: default `DIV_W`, `NCH` and `SEL_W`; a `div_t` typedef of logic [DIV_W−1:0]; named divide constants for 1 kHz scan and 2 Hz blink at the board clock.
- Sub-module `clkdiv_channel`: one counter with its `act`/`pend` registers and `tick`/`sq` flops. The top level decodes `div_sel` into per-channel write enables and instantiates `clkdiv_channel` NCH times with a generate loop.

## Test plan
- Reset defaults: assert `rst` mid-count → `tick`=0, `sq`=0 and `cnt`=0 immediately; with DIV_W=4, the first tick comes 16 cycles after release.
- Write N=3 to channel 1, then `sync` → `tick[1]` high exactly every 4 cycles; `sq[1]` has an 8-cycle period with 4 high and 4 low.
- N=0 on channel 0 → `tick[0]` is constantly high while `en`=1; dropping `en` for 5 cycles → `tick` is low and `cnt` and `sq` hold; the pattern resumes with no extra tick.
- While N=9 runs, write N=2 at `cnt`=4 → the current period still lasts 10 cycles, then periods are 3 cycles; also cover a write on the terminal-count cycle (bypass takes effect) and `div_sel`=NCH (ignored).
- `sync` asserted in the same cycle as a terminal count with `en`=0 → no tick, all `cnt`=0 and `sq`=0, and all channels with equal N then tick on the same cycle.
- Build without `CLKDIV_SQUARE_EN` → `sq` is always 0, and the `tick` waveform is identical to the previous cases.
